icache_fetch_unit: RTL and testbench

Instruction-fetch responder that serves the IF stage's PC requests. It holds a direct-mapped, one-word-per-line instruction cache and refills it from the external base SRAM through a wait-state-counting read FSM. A hit returns the instruction combinationally in the same cycle. A miss raises a stall request until the word is read from SRAM.

---
 rtl/icache_fetch_unit.sv | 128 ++++++++++++
 tb/tb_icache_fetch_unit.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/icache_fetch_unit.sv
// rtl/icache_fetch_unit.sv - direct-mapped one-word-per-line instruction cache with SRAM refill FSM
module icache_fetch_unit #(
  parameter int LINES       = 16,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_i,
  input  logic        ce_n_i,
  input  logic        invalidate_i,
  input  logic        bus_busy_i,
  output logic [31:0] inst_o,
  output logic        hit_o,
  output logic        stall_req_o,
  output logic [19:0] sram_addr_o,
  input  logic [31:0] sram_data_i,
  output logic        sram_ce_n_o,
  output logic        sram_oe_n_o,
  output logic        sram_we_n_o,
  output logic [3:0]  sram_be_n_o
);

  localparam int          IDX      = $clog2(LINES);
  localparam int          TAGW     = 30 - IDX;
  localparam logic [31:0] NOP      = 32'h00000013;
  localparam logic [2:0]  WAIT_CNT = 3'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, WAIT_BUS, ACCESS, DONE} state_t;

  state_t           state;
  logic [2:0]       cnt;
  logic [31:0]      req_pc;
  logic [31:0]      fill_reg;
  logic             abort;
  logic [LINES-1:0] valid;
  logic [TAGW-1:0]  tag_arr  [LINES];
  logic [31:0]      data_arr [LINES];

  logic [IDX-1:0]  idx;
  logic [IDX-1:0]  req_idx;
  logic [TAGW-1:0] tag;
  logic            hit;
  logic            miss;
  logic            fill_now;

  assign idx      = pc_i[IDX+1:2];
  assign tag      = pc_i[31:IDX+2];
  assign req_idx  = req_pc[IDX+1:2];
  assign fill_now = (state == ACCESS) && (cnt == 3'd0);

  // A pending invalidate turns a would-be hit into a miss in the same cycle.
  assign hit  = (state == IDLE) && !ce_n_i && !invalidate_i && valid[idx] && (tag_arr[idx] == tag);
  assign miss = (state == IDLE) && !ce_n_i && !hit;

  always_comb begin
    hit_o       = hit;
    stall_req_o = miss || (state == WAIT_BUS) || (state == ACCESS);
    if (state == DONE)
      inst_o = fill_reg;
    else if (hit)
      inst_o = data_arr[idx];
    else
      inst_o = NOP;
  end

  assign sram_ce_n_o = (state != ACCESS);
  assign sram_oe_n_o = (state != ACCESS);
  assign sram_we_n_o = 1'b1;
  assign sram_be_n_o = 4'b0000;
  assign sram_addr_o = req_pc[21:2];

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 3'd0;
      req_pc   <= 32'd0;
      fill_reg <= NOP;
      abort    <= 1'b0;
      valid    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (miss) begin
            req_pc <= pc_i;
            if (bus_busy_i) begin
              state <= WAIT_BUS;
            end else begin
              state <= ACCESS;
              cnt   <= WAIT_CNT;
            end
          end
        end
        WAIT_BUS: begin
          if (invalidate_i) abort <= 1'b1;
          if (!bus_busy_i) begin
            state <= ACCESS;
            cnt   <= WAIT_CNT;
          end
        end
        ACCESS: begin
          if (invalidate_i) abort <= 1'b1;
          if (cnt != 3'd0) begin
            cnt <= cnt - 3'd1;
          end else begin
            fill_reg       <= sram_data_i;
            valid[req_idx] <= !abort && !invalidate_i;
            state          <= DONE;
          end
        end
        DONE: begin
          abort <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // Whole-array clear overrides any fill landing on the same edge.
      if (invalidate_i) valid <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && fill_now) begin
      tag_arr[req_idx]  <= req_pc[31:IDX+2];
      data_arr[req_idx] <= sram_data_i;
    end
  end

endmodule

// File: tb/tb_icache_fetch_unit.sv
// tb/tb_icache_fetch_unit.sv - directed bench with line-map cache model for icache_fetch_unit
module tb_icache_fetch_unit;
  localparam int          LINES = 16;
  localparam int          W     = 1;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_i;
  logic        ce_n_i;
  logic        invalidate_i;
  logic        bus_busy_i;
  logic [31:0] inst_o;
  logic        hit_o;
  logic        stall_req_o;
  logic [19:0] sram_addr_o;
  logic [31:0] sram_data_i;
  logic        sram_ce_n_o;
  logic        sram_oe_n_o;
  logic        sram_we_n_o;
  logic [3:0]  sram_be_n_o;

  icache_fetch_unit #(.LINES(LINES), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .pc_i(pc_i), .ce_n_i(ce_n_i), .invalidate_i(invalidate_i),
    .bus_busy_i(bus_busy_i), .inst_o(inst_o), .hit_o(hit_o), .stall_req_o(stall_req_o),
    .sram_addr_o(sram_addr_o), .sram_data_i(sram_data_i), .sram_ce_n_o(sram_ce_n_o),
    .sram_oe_n_o(sram_oe_n_o), .sram_we_n_o(sram_we_n_o), .sram_be_n_o(sram_be_n_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: line index -> pc currently held valid in that line.
  logic [31:0] mline [int];
  int          obs_stall;
  logic [31:0] obs_inst;
  logic [19:0] obs_addr;
  logic        obs_hit;

  function automatic logic [31:0] memf(input logic [19:0] a);
    if (a == 20'h0) return 32'h00000513;
    return {a, 12'h013};
  endfunction

  always_comb sram_data_i = memf(sram_addr_o);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_fixed;
    chk("we_n", sram_we_n_o, 1);
    chk("be_n", sram_be_n_o, 0);
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) begin
      ce_n_i = 1'b1; bus_busy_i = 1'b0; invalidate_i = 1'b0;
      @(negedge clk);
      chk("idle_stall", stall_req_o, 0);
      chk("idle_hit", hit_o, 0);
      chk("idle_inst", inst_o, NOP);
      chk("idle_ce_n", sram_ce_n_o, 1);
      chk("idle_oe_n", sram_oe_n_o, 1);
      chk_fixed();
      @(posedge clk); #1;
    end
  endtask

  // One fetch from request to delivery; busy = cycles of bus_busy_i from detect,
  // inval_at = cycle (0 = detect) of an invalidate pulse, -1 for none.
  task automatic fetch(input logic [31:0] pc, input int busy, input int inval_at);
    int          idx;
    int          len;
    bit          mhit;
    bit          acc;
    logic [31:0] w;
    idx = int'((pc >> 2) % LINES);
    w   = memf(pc[21:2]);
    if (inval_at == 0) mline.delete();
    mhit = mline.exists(idx) && (mline[idx] == pc);
    len  = mhit ? 0 : busy + W + 2;
    obs_stall = 0;
    for (int c = 0; c <= len; c++) begin
      pc_i = pc; ce_n_i = 1'b0;
      bus_busy_i   = (c < busy);
      invalidate_i = (c == inval_at);
      @(negedge clk);
      chk_fixed();
      if (stall_req_o) obs_stall++;
      if (c < len) begin
        acc = (c > busy);
        chk("miss_stall", stall_req_o, 1);
        chk("miss_hit", hit_o, 0);
        chk("miss_inst", inst_o, NOP);
        chk("miss_ce_n", sram_ce_n_o, !acc);
        chk("miss_oe_n", sram_oe_n_o, !acc);
        if (acc) begin
          chk("miss_addr", sram_addr_o, pc[21:2]);
          obs_addr = sram_addr_o;
        end
      end else begin
        chk("deliver_stall", stall_req_o, 0);
        chk("deliver_hit", hit_o, mhit);
        chk("deliver_inst", inst_o, w);
        chk("deliver_ce_n", sram_ce_n_o, 1);
        obs_inst = inst_o;
        obs_hit  = hit_o;
      end
      @(posedge clk); #1;
    end
    invalidate_i = 1'b0; bus_busy_i = 1'b0;
    if (!mhit && inval_at > 0) mline.delete();
    else mline[idx] = pc;
  endtask

  initial begin
    rst = 1'b1; ce_n_i = 1'b1; pc_i = 32'h0; invalidate_i = 1'b0; bus_busy_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle(10);

    fetch(32'h80000000, 0, -1);
    chk("cold_stall_len", obs_stall, 3);
    chk("cold_inst", obs_inst, 32'h00000513);
    chk("cold_addr", obs_addr, 20'h00000);
    fetch(32'h80000000, 0, -1);
    chk("rehit_flag", obs_hit, 1);
    chk("rehit_inst", obs_inst, 32'h00000513);

    fetch(32'h80000040, 0, -1);
    chk("evict_addr2", obs_addr, 20'h00010);
    fetch(32'h80000000, 0, -1);
    chk("evict_addr3", obs_addr, 20'h00000);
    chk("evict_rehit", obs_hit, 0);

    fetch(32'h80000004, 2, -1);
    chk("busy_stall_len", obs_stall, W + 4);
    fetch(32'h80000004, 0, -1);
    idle(2);
    fetch(32'h80000004, 0, 0);
    chk("idle_inval_miss", obs_stall, 3);
    fetch(32'h80000004, 0, -1);

    fetch(32'h80000008, 0, 1);
    chk("abort_inst", obs_inst, {20'h00002, 12'h013});
    fetch(32'h80000008, 0, -1);
    fetch(32'h80000004, 0, -1);
    chk("abort_other_miss", obs_hit, 0);
    fetch(32'h8000000C, 1, 2);
    fetch(32'h8000000C, 0, -1);
    fetch(32'h8000000C, 0, -1);
    fetch(32'h80000008, 0, -1);

    pc_i = 32'h80000100; ce_n_i = 1'b0;
    @(negedge clk);
    chk("rst_seq_detect", stall_req_o, 1);
    @(posedge clk); #1;
    rst = 1'b1; ce_n_i = 1'b1;
    @(negedge clk);
    chk("rst_seq_access", sram_ce_n_o, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_seq_ce_n", sram_ce_n_o, 1);
    chk("rst_seq_oe_n", sram_oe_n_o, 1);
    chk("rst_seq_we_n", sram_we_n_o, 1);
    chk("rst_seq_stall", stall_req_o, 0);
    chk("rst_seq_inst", inst_o, NOP);
    @(posedge clk); #1;
    mline.delete();
    fetch(32'h80000100, 0, -1);
    chk("rst_refetch_stall", obs_stall, 3);
    fetch(32'h80000008, 0, -1);
    chk("rst_cleared_line", obs_hit, 0);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
